// File: rtl/dmem_resp_pkg.sv
// Shared types and defaults for the dmem_responder data-memory slave.
// Address checking is enabled by defining DMEM_RESP_ERR_EN.
package dmem_resp_pkg;

   localparam int DEF_DEPTH       = 64;
   localparam int DEF_WAIT_STATES = 2;
   localparam int CNT_W           = 4;   // holds WAIT_STATES-1 for WAIT_STATES up to 15

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Misaligned or past the end of storage.
   function automatic logic addr_bad(input logic [31:0] addr, input int depth);
      return (addr[1:0] != 2'b00) || (addr >= 32'(4 * depth));
   endfunction

endpackage

// File: rtl/dmem_resp_array.sv
// Single-port word storage: synchronous write, registered read, no reset on contents.
module dmem_resp_array #(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) mem[addr] <= wdata;
         else    rdata     <= mem[addr];
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request in flight, fixed WAIT_STATES latency.
// Define DMEM_RESP_ERR_EN to reject misaligned / out-of-range addresses.
module dmem_responder
   import dmem_resp_pkg::*;
#(
   parameter int DEPTH       = DEF_DEPTH,
   parameter int WAIT_STATES = DEF_WAIT_STATES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int AW      = $clog2(DEPTH);
   localparam bit NO_WAIT = (WAIT_STATES == 0);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             we_q;
   logic [AW-1:0]    idx_q;
   logic [31:0]      wdata_q;
   logic             err_q;
   logic             valid_q;
   logic             err_r;
   logic             rd_sel;

   logic             in_err;
   logic             accept;
   logic             go_now;
   logic             go_wait;
   logic             arr_en;
   logic             arr_we;
   logic [AW-1:0]    arr_addr;
   logic [31:0]      arr_wdata;
   logic [31:0]      arr_rdata;

`ifdef DMEM_RESP_ERR_EN
   assign in_err = addr_bad(req_addr, DEPTH);
`else
   assign in_err = 1'b0;
   logic unused_addr_bits;
   assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};
`endif

   // Registered state only; reset masks it so nothing is accepted during reset.
   assign req_ready = (state == IDLE) && !reset;
   assign accept    = req_valid && req_ready;

   // The array is accessed on the edge that enters RESP. With no wait states
   // that is the accept edge itself, so the live request drives the array.
   assign go_now  = NO_WAIT && (state == IDLE) && accept;
   assign go_wait = (state == WAIT) && (cnt == '0);

   assign arr_en    = !reset && ((go_now && !in_err) || (go_wait && !err_q));
   assign arr_we    = go_now ? req_we               : we_q;
   assign arr_addr  = go_now ? req_addr[AW+1:2]     : idx_q;
   assign arr_wdata = go_now ? req_wdata            : wdata_q;

   dmem_resp_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk   (clk),
      .en    (arr_en),
      .we    (arr_we),
      .addr  (arr_addr),
      .wdata (arr_wdata),
      .rdata (arr_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         we_q    <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
         err_r   <= 1'b0;
         rd_sel  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  we_q    <= req_we;
                  idx_q   <= req_addr[AW+1:2];
                  wdata_q <= req_wdata;
                  err_q   <= in_err;
                  if (NO_WAIT) begin
                     state   <= RESP;
                     valid_q <= 1'b1;
                     err_r   <= in_err;
                     rd_sel  <= !req_we && !in_err;
                  end else begin
                     state <= WAIT;
                     cnt   <= CNT_W'(WAIT_STATES - 1);
                  end
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  state   <= RESP;
                  valid_q <= 1'b1;
                  err_r   <= err_q;
                  rd_sel  <= !we_q && !err_q;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  state   <= IDLE;
                  valid_q <= 1'b0;
                  err_r   <= 1'b0;
                  rd_sel  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // rd_sel is only set alongside valid_q, so data reads as 0 outside RESP
   // and for writes / rejected requests.
   assign resp_valid = valid_q;
   assign resp_err   = err_r;
   assign resp_rdata = rd_sel ? arr_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed + randomized bench for dmem_responder (WAIT_STATES=2 and 0 instances).
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        req_ready, resp_valid, resp_err;
   logic [31:0] resp_rdata;

   logic        z_valid = 1'b0, z_we = 1'b0, z_resp_ready = 1'b0;
   logic [31:0] z_addr = '0, z_wdata = '0;
   logic        z_req_ready, z_resp_valid, z_resp_err;
   logic [31:0] z_resp_rdata;

   int n_chk = 0;
   int n_pass = 0;

`ifdef DMEM_RESP_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH(64), .WAIT_STATES(2)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   dmem_responder #(.DEPTH(64), .WAIT_STATES(0)) dut0 (
      .clk(clk), .reset(reset),
      .req_valid(z_valid), .req_ready(z_req_ready), .req_we(z_we),
      .req_addr(z_addr), .req_wdata(z_wdata),
      .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
      .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
   );

   // One request on dut; called at a negedge. lat=1 means resp_valid was seen
   // in the first cycle after the accept edge.
   task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input int stall, output logic [31:0] rd, output logic er,
                       output int lat, output bit ok, output bit stable, output bit after_ok);
      int t = 0;
      ok = 1'b1; stable = 1'b1; after_ok = 1'b0; rd = '0; er = 1'b0; lat = 0;
      while (!req_ready && t < 20) begin @(negedge clk); t++; end
      if (!req_ready) begin ok = 1'b0; return; end
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
      resp_ready = (stall == 0);
      @(negedge clk);
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      lat = 1;
      while (!resp_valid && lat < 40) begin @(negedge clk); lat++; end
      if (!resp_valid) begin ok = 1'b0; return; end
      rd = resp_rdata; er = resp_err;
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         if (!resp_valid || resp_rdata !== rd || resp_err !== er || req_ready) stable = 1'b0;
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      after_ok = !resp_valid && req_ready && (resp_rdata == 32'h0) && !resp_err;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_chk++;
      if ({req_ready, resp_valid, resp_err, resp_rdata} !== 35'h0)
         $display("FAIL reset_outputs: got rdy=%b vld=%b err=%b rd=%h required 0", req_ready, resp_valid, resp_err, resp_rdata);
      else n_pass++;
      reset = 1'b0;
      #1;
      n_chk++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0)
         $display("FAIL reset_release: got rdy=%b vld=%b required rdy=1 vld=0", req_ready, resp_valid);
      else n_pass++;
      n_chk++;
      if (z_req_ready !== 1'b1 || z_resp_valid !== 1'b0)
         $display("FAIL reset_release_ws0: got rdy=%b vld=%b required rdy=1 vld=0", z_req_ready, z_resp_valid);
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_write_read();
      logic [31:0] rd; logic er; int lat; bit ok, st, aft;
      xact(1'b1, 32'h10, 32'hDEADBEEF, 0, rd, er, lat, ok, st, aft);
      n_chk++;
      if (!ok || lat != 3) $display("FAIL wr_latency: got %0d (ok=%b) required 3", lat, ok); else n_pass++;
      n_chk++;
      if (rd !== 32'h0 || er !== 1'b0) $display("FAIL wr_resp: got rd=%h err=%b required 0/0", rd, er); else n_pass++;
      n_chk++;
      if (!aft) $display("FAIL wr_after: got %b required 1 (idle, ready, zero data)", aft); else n_pass++;
      xact(1'b0, 32'h10, 32'h0, 0, rd, er, lat, ok, st, aft);
      n_chk++;
      if (!ok || lat != 3) $display("FAIL rd_latency: got %0d (ok=%b) required 3", lat, ok); else n_pass++;
      n_chk++;
      if (rd !== 32'hDEADBEEF || er !== 1'b0) $display("FAIL rd_data: got %h err=%b required deadbeef/0", rd, er); else n_pass++;
      n_chk++;
      if (!aft) $display("FAIL rd_after: got %b required 1", aft); else n_pass++;
   endtask

   task automatic test_ws0_stall();
      bit bad = 1'b0;
      z_valid = 1'b1; z_we = 1'b1; z_addr = 32'h10; z_wdata = 32'hCAFEF00D; z_resp_ready = 1'b1;
      @(negedge clk);
      z_valid = 1'b0; z_we = 1'b0;
      n_chk++;
      if (z_resp_valid !== 1'b1) $display("FAIL ws0_wr_latency: got vld=%b required 1", z_resp_valid); else n_pass++;
      @(negedge clk);
      z_resp_ready = 1'b0;
      z_valid = 1'b1; z_addr = 32'h10;
      @(negedge clk);
      z_valid = 1'b0;
      n_chk++;
      if (z_resp_valid !== 1'b1 || z_resp_rdata !== 32'hCAFEF00D)
         $display("FAIL ws0_rd_latency: got vld=%b rd=%h required 1/cafef00d", z_resp_valid, z_resp_rdata);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (z_resp_valid !== 1'b1 || z_resp_rdata !== 32'hCAFEF00D || z_req_ready !== 1'b0) bad = 1'b1;
      end
      n_chk++;
      if (bad) $display("FAIL ws0_stall_hold: got vld=%b rd=%h rdy=%b required 1/cafef00d/0", z_resp_valid, z_resp_rdata, z_req_ready);
      else n_pass++;
      z_resp_ready = 1'b1;
      @(negedge clk);
      z_resp_ready = 1'b0;
      n_chk++;
      if (z_resp_valid !== 1'b0 || z_req_ready !== 1'b1 || z_resp_rdata !== 32'h0)
         $display("FAIL ws0_release: got vld=%b rdy=%b rd=%h required 0/1/0", z_resp_valid, z_req_ready, z_resp_rdata);
      else n_pass++;
   endtask

   task automatic test_reset_abort();
      logic [31:0] rd; logic er; int lat; bit ok, st, aft;
      xact(1'b1, 32'h20, 32'hA5A5A5A5, 0, rd, er, lat, ok, st, aft);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
      @(negedge clk);
      req_valid = 1'b0; req_we = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      n_chk++;
      if (req_ready !== 1'b0 || resp_valid !== 1'b0)
         $display("FAIL abort_in_reset: got rdy=%b vld=%b required 0/0", req_ready, resp_valid);
      else n_pass++;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_chk++;
      if (resp_valid !== 1'b0) $display("FAIL abort_no_resp: got vld=%b required 0", resp_valid); else n_pass++;
      xact(1'b0, 32'h20, 32'h0, 0, rd, er, lat, ok, st, aft);
      n_chk++;
      if (!ok || rd !== 32'hA5A5A5A5) $display("FAIL abort_no_commit: got %h required a5a5a5a5", rd); else n_pass++;
   endtask

   task automatic test_addr_range();
      logic [31:0] rd, exp; logic er; int lat; bit ok, st, aft;
      xact(1'b1, 32'h0, 32'h11112222, 0, rd, er, lat, ok, st, aft);
      exp = ERR_EN ? 32'h0 : 32'h11112222;
      xact(1'b0, 32'h102, 32'h0, 0, rd, er, lat, ok, st, aft);
      n_chk++;
      if (!ok || lat != 3 || rd !== exp || er !== ERR_EN)
         $display("FAIL addr_102: got rd=%h err=%b lat=%0d required %h/%b/3", rd, er, lat, exp, ERR_EN);
      else n_pass++;
      xact(1'b0, 32'h100, 32'h0, 0, rd, er, lat, ok, st, aft);
      n_chk++;
      if (!ok || lat != 3 || rd !== exp || er !== ERR_EN)
         $display("FAIL addr_100: got rd=%h err=%b lat=%0d required %h/%b/3", rd, er, lat, exp, ERR_EN);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [31:0] mdl [64];
      logic [31:0] rd, a, wd, exp; logic er, we, eerr; int lat, stall; bit ok, st, aft;
      for (int i = 0; i < 64; i++) begin
         mdl[i] = $urandom;
         xact(1'b1, 32'(i * 4), mdl[i], 0, rd, er, lat, ok, st, aft);
      end
      for (int n = 0; n < 1000; n++) begin
         we = 1'($urandom_range(0, 1));
         a = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 1023)) : 32'($urandom_range(0, 63) * 4);
         wd = $urandom;
         stall = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
         eerr = ERR_EN && (a[1:0] != 2'b00 || a >= 32'd256);
         exp = 32'h0;
         if (!eerr) begin
            if (we) mdl[a[7:2]] = wd;
            else    exp = mdl[a[7:2]];
         end
         xact(we, a, wd, stall, rd, er, lat, ok, st, aft);
         n_chk++;
         if (!ok || lat != 3 || rd !== exp || er !== eerr || !st || !aft)
            $display("FAIL rand_%0d: got we=%b a=%h rd=%h err=%b lat=%0d ok=%b st=%b aft=%b required rd=%h err=%b lat=3",
                     n, we, a, rd, er, lat, ok, st, aft, exp, eerr);
         else n_pass++;
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_write_read();
      test_ws0_stall();
      test_reset_abort();
      test_addr_range();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
